// File: rtl/param_loader.sv
// Framed byte-stream loader for the risk core's mu/sigma/S operands.
// Validates pad bits and XOR checksum, then commits the new set once the core is idle.
module param_loader #(
   parameter logic [7:0] HDR     = 8'hA5,
   parameter int         TIMEOUT = 1024
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [7:0]  iData,
   input  logic        iValid,
   output logic        oReady,
   input  logic        iBusy,
   output logic [17:0] oMu,
   output logic [17:0] oSigma,
   output logic [17:0] oS,
   output logic        oLoad,
   output logic        oErr,
   output logic [1:0]  oErrCode
);

   localparam int GW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 2);

   typedef enum logic [1:0] {IDLE, PAYLOAD, CSUM, COMMIT} stateT;

   stateT          state, stateNext;
   logic [3:0]     idx;
   logic [7:0]     acc;
   logic           padFlag;
   logic [GW-1:0]  gap;
   logic [53:0]    shadow;
   logic           xfer, timeUp, csumBad, padPos;

   assign xfer    = iValid & oReady;
   assign timeUp  = !xfer && (gap == GAP_LAST);
   assign csumBad = (iData != acc);
   assign padPos  = (idx == 4'd0) || (idx == 4'd3) || (idx == 4'd6);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= stateNext;
   end

   // NOTE: default assignment first so no path leaves stateNext unassigned (no latch).
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (xfer && iData == HDR) stateNext = PAYLOAD;
         PAYLOAD: if (xfer && idx == 4'd8) stateNext = CSUM;
                  else if (timeUp)          stateNext = IDLE;
         CSUM:    if (xfer)                 stateNext = (csumBad || padFlag) ? IDLE : COMMIT;
                  else if (timeUp)          stateNext = IDLE;
         COMMIT:  if (!iBusy)               stateNext = IDLE;
         default:                           stateNext = IDLE;
      endcase
   end

   always_comb begin
      oReady = 1'b1;
      if (state == COMMIT) oReady = 1'b0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         idx      <= '0;
         acc      <= '0;
         padFlag  <= 1'b0;
         gap      <= '0;
         oMu      <= '0;
         oSigma   <= '0;
         oS       <= '0;
         oLoad    <= 1'b0;
         oErr     <= 1'b0;
         oErrCode <= 2'b00;
      end else begin
         oLoad <= 1'b0;
         oErr  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (xfer && iData == HDR) begin
                  idx     <= '0;
                  acc     <= '0;
                  padFlag <= 1'b0;
                  gap     <= '0;
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  idx     <= idx + 4'd1;
                  acc     <= acc ^ iData;
                  padFlag <= padFlag | (padPos & (|iData[7:2]));
                  gap     <= '0;
               end else begin
                  gap <= gap + GW'(1);
                  if (timeUp) begin
                     oErr     <= 1'b1;
                     oErrCode <= 2'b11;
                  end
               end
            end
            CSUM: begin
               if (xfer) begin
                  gap <= '0;
                  if (csumBad) begin
                     oErr     <= 1'b1;
                     oErrCode <= 2'b01;
                  end else if (padFlag) begin
                     oErr     <= 1'b1;
                     oErrCode <= 2'b10;
                  end
               end else begin
                  gap <= gap + GW'(1);
                  if (timeUp) begin
                     oErr     <= 1'b1;
                     oErrCode <= 2'b11;
                  end
               end
            end
            COMMIT: begin
               if (!iBusy) begin
                  oMu    <= shadow[53:36];
                  oSigma <= shadow[35:18];
                  oS     <= shadow[17:0];
                  oLoad  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: shadow is pure data, fully rewritten by every frame, so it carries no reset.
   // Pad bytes contribute only their two value bits, packing the three operands into 54 bits.
   always_ff @(posedge CLK) begin
      if (state == PAYLOAD && xfer) begin
         if (padPos) shadow <= {shadow[51:0], iData[1:0]};
         else        shadow <= {shadow[45:0], iData};
      end
   end

endmodule

// File: tb/tb_param_loader.sv
// Randomized bench for param_loader against a frame-level reference model.
// Directed scenarios pin literal values; a per-cycle compare covers everything else.
module tb_param_loader;

   localparam logic [7:0] HDR     = 8'hA5;
   localparam int         TIMEOUT = 32;

   typedef logic [7:0] frameT [11];

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [7:0]  iData = 8'h00;
   logic        iValid = 1'b0;
   logic        iBusy = 1'b0;
   logic        oReady;
   logic [17:0] oMu, oSigma, oS;
   logic        oLoad, oErr;
   logic [1:0]  oErrCode;

   int errors = 0;
   int checks = 0;
   bit busyRand = 1'b0;

   always #5 CLK = ~CLK;

   param_loader #(.HDR(HDR), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST_N(RST_N), .iData(iData), .iValid(iValid), .oReady(oReady),
      .iBusy(iBusy), .oMu(oMu), .oSigma(oSigma), .oS(oS),
      .oLoad(oLoad), .oErr(oErr), .oErrCode(oErrCode)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: frames as byte lists ----------------
   bit          pending = 1'b0;
   bit          inFrame = 1'b0;
   logic [7:0]  fr[$];
   int          gapCnt = 0;
   logic [17:0] pMu = '0, pSigma = '0, pS = '0;
   logic [17:0] eMu = '0, eSigma = '0, eS = '0;
   bit          eLoad = 1'b0, eErr = 1'b0;
   logic [1:0]  eCode = 2'b00;

   task automatic judgeFrame();
      logic [7:0]  x;
      logic [23:0] w;
      bit          pad;
      x = 8'h00;
      for (int i = 0; i < 9; i++) x ^= fr[i];
      pad = (fr[0] > 8'd3) || (fr[3] > 8'd3) || (fr[6] > 8'd3);
      if (fr[9] != x) begin
         eErr = 1'b1; eCode = 2'b01;
      end else if (pad) begin
         eErr = 1'b1; eCode = 2'b10;
      end else begin
         pending = 1'b1;
         w = {fr[0], fr[1], fr[2]}; pMu    = w[17:0];
         w = {fr[3], fr[4], fr[5]}; pSigma = w[17:0];
         w = {fr[6], fr[7], fr[8]}; pS     = w[17:0];
      end
   endtask

   task automatic modelStep();
      bit xfer;
      xfer  = iValid && !pending;
      eLoad = 1'b0;
      eErr  = 1'b0;
      if (pending) begin
         if (!iBusy) begin
            eMu = pMu; eSigma = pSigma; eS = pS;
            eLoad = 1'b1;
            pending = 1'b0;
         end
      end else if (!inFrame) begin
         if (xfer && iData == HDR) begin
            inFrame = 1'b1;
            fr.delete();
            gapCnt = 0;
         end
      end else if (xfer) begin
         fr.push_back(iData);
         gapCnt = 0;
         if (fr.size() == 10) begin
            judgeFrame();
            inFrame = 1'b0;
         end
      end else begin
         gapCnt++;
         if (gapCnt == TIMEOUT - 1) begin
            eErr = 1'b1; eCode = 2'b11;
            inFrame = 1'b0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) begin
            pending = 1'b0; inFrame = 1'b0; fr.delete(); gapCnt = 0;
            eMu = '0; eSigma = '0; eS = '0;
            eLoad = 1'b0; eErr = 1'b0; eCode = 2'b00;
         end else begin
            modelStep();
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         check("cmp_oReady",   oReady,   !pending);
         check("cmp_oLoad",    oLoad,    eLoad);
         check("cmp_oErr",     oErr,     eErr);
         check("cmp_oErrCode", oErrCode, eCode);
         check("cmp_oMu",      oMu,      eMu);
         check("cmp_oSigma",   oSigma,   eSigma);
         check("cmp_oS",       oS,       eS);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge CLK);
      if (busyRand) iBusy = ($urandom_range(0, 2) == 0);
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic sendByte(input logic [7:0] b);
      logic r;
      iValid = 1'b1;
      iData  = b;
      for (int n = 0; n < 300; n++) begin
         r = oReady;
         step();
         if (r) begin
            iValid = 1'b0;
            iData  = 8'($urandom);
            return;
         end
      end
      check("handshake_bound", 32'd0, 32'd1);
      iValid = 1'b0;
   endtask

   task automatic sendFrame(input frameT f, input int maxGap);
      for (int i = 0; i < 11; i++) begin
         sendByte(f[i]);
         if (maxGap > 0 && i < 10) idle($urandom_range(0, maxGap));
      end
   endtask

   task automatic fixCsum(inout frameT f);
      f[10] = 8'h00;
      for (int i = 1; i < 10; i++) f[10] ^= f[i];
   endtask

   task automatic makeFrame(input logic [17:0] mu, input logic [17:0] sg,
                            input logic [17:0] s, output frameT f);
      f[0] = HDR;
      f[1] = {6'd0, mu[17:16]}; f[2] = mu[15:8]; f[3] = mu[7:0];
      f[4] = {6'd0, sg[17:16]}; f[5] = sg[15:8]; f[6] = sg[7:0];
      f[7] = {6'd0, s[17:16]};  f[8] = s[15:8];  f[9] = s[7:0];
      fixCsum(f);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      frameT base, f;
      int k, kind, m;

      base = '{8'hA5, 8'h00, 8'h00, 8'hB8, 8'h00, 8'h0D, 8'h50, 8'h00, 8'h60, 8'h00, 8'h85};

      repeat (2) @(negedge CLK);
      #2 RST_N = 1'b1;
      @(negedge CLK);
      check("reset_mu",     oMu,      18'd0);
      check("reset_ready",  oReady,   1'b1);
      check("reset_code",   oErrCode, 2'b00);

      makeFrame(18'd184, 18'd3408, 18'd24576, f);
      check("model_csum", f[10], 8'h85);

      // Basic frame, core idle.
      sendFrame(base, 0);
      check("t1_noload_yet", oLoad, 1'b0);
      @(negedge CLK);
      check("t1_load",  oLoad,  1'b1);
      check("t1_mu",    oMu,    18'd184);
      check("t1_sigma", oSigma, 18'd3408);
      check("t1_s",     oS,     18'd24576);
      @(negedge CLK);
      check("t1_load_off", oLoad, 1'b0);

      // Commit deferred by busy core.
      makeFrame(18'h2ABCD, 18'h00001, 18'h3FFFF, f);
      iBusy = 1'b1;
      sendFrame(f, 0);
      idle(20);
      check("t2_ready_low", oReady, 1'b0);
      check("t2_mu_held",   oMu,    18'd184);
      iBusy = 1'b0;
      @(negedge CLK);
      check("t2_load", oLoad, 1'b1);
      check("t2_mu",   oMu,   18'h2ABCD);
      check("t2_s",    oS,    18'h3FFFF);

      // Bad checksum, then garbage, then a good frame.
      f = base;
      f[10] = 8'h84;
      sendFrame(f, 0);
      check("t3_err",    oErr,     1'b1);
      check("t3_code",   oErrCode, 2'b01);
      check("t3_mu_kept", oMu,     18'h2ABCD);
      sendByte(8'h11);
      sendByte(8'h22);
      sendFrame(base, 0);
      @(negedge CLK);
      check("t3_load", oLoad, 1'b1);
      check("t3_mu",   oMu,   18'd184);

      // Nonzero pad with a correct checksum.
      f = base;
      f[1] = 8'h04;
      f[10] = 8'h81;
      sendFrame(f, 0);
      check("t4_err",  oErr,     1'b1);
      check("t4_code", oErrCode, 2'b10);
      @(negedge CLK);
      check("t4_noload", oLoad, 1'b0);

      // Inter-byte timeout.
      sendByte(HDR);
      for (int i = 1; i <= 4; i++) sendByte(base[i]);
      k = 0;
      for (int i = 1; i <= TIMEOUT + 4; i++) begin
         @(negedge CLK);
         if (oErr) begin k = i; break; end
      end
      check("t5_gap",  k,        TIMEOUT - 1);
      check("t5_code", oErrCode, 2'b11);
      makeFrame(18'h12345, 18'h0ABCD, 18'h00777, f);
      sendFrame(f, 2);
      @(negedge CLK);
      check("t5_load", oLoad, 1'b1);
      check("t5_s",    oS,    18'h00777);

      // Reset mid-payload.
      sendByte(HDR);
      for (int i = 1; i <= 3; i++) sendByte(base[i]);
      #2 RST_N = 1'b0;
      #1;
      check("t6_mu",    oMu,      18'd0);
      check("t6_sigma", oSigma,   18'd0);
      check("t6_code",  oErrCode, 2'b00);
      check("t6_ready", oReady,   1'b1);
      @(negedge CLK);
      #2 RST_N = 1'b1;
      @(negedge CLK);

      // Reset while a commit is pending.
      iBusy = 1'b1;
      sendFrame(base, 0);
      idle(3);
      #2 RST_N = 1'b0;
      #1;
      check("t7_ready", oReady, 1'b1);
      check("t7_s",     oS,     18'd0);
      @(negedge CLK);
      #2 RST_N = 1'b1;
      iBusy = 1'b0;
      idle(10);
      check("t7_mu_zero", oMu, 18'd0);

      // Randomized traffic.
      busyRand = 1'b1;
      for (int it = 0; it < 150; it++) begin
         kind = $urandom_range(0, 9);
         makeFrame(18'($urandom), 18'($urandom), 18'($urandom), f);
         case (kind)
            5: begin
               f[10] ^= 8'(1 << $urandom_range(0, 7));
               sendFrame(f, 3);
            end
            6: begin
               m = 1 + 3 * $urandom_range(0, 2);
               f[m] |= 8'(4 << $urandom_range(0, 5));
               fixCsum(f);
               sendFrame(f, 3);
            end
            7: begin
               sendByte(HDR);
               m = $urandom_range(0, 9);
               for (int i = 1; i <= m; i++) sendByte(f[i]);
               idle(TIMEOUT + 2);
            end
            8: begin
               m = $urandom_range(1, 4);
               for (int i = 0; i < m; i++) begin
                  logic [7:0] g;
                  g = 8'($urandom);
                  if (g == HDR) g = 8'h00;
                  sendByte(g);
               end
            end
            9: begin
               f[4] |= 8'h80;
               f[10] ^= 8'h01;
               sendFrame(f, 3);
            end
            default: sendFrame(f, 3);
         endcase
         idle($urandom_range(0, 2));
      end
      busyRand = 1'b0;
      iBusy = 1'b0;
      idle(TIMEOUT + 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/param_loader.md
# param_loader

Byte-stream parameter loader that sits in front of `Main`, on the producer side of its `iMu`/`iSigma`/`iS` inputs. It receives framed parameter sets over an 8-bit valid/ready stream, checks framing, padding and checksum, and holds the three 18-bit operands stable. It commits a new set only when the risk core is idle, and then issues a one-cycle load strobe. Rejected frames leave the previous operands untouched and raise an error pulse with a code.

## Interface
- `HDR`, 8'hA5, frame header byte.
- `TIMEOUT`, 1024, maximum idle cycles between accepted bytes inside a frame (≥2).
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: reset, asynchronous and active-low.
- `iData` input 8: stream byte.
- `iValid` input 1: `iData` valid.
- `oReady` output 1: loader can accept a byte; a byte transfers on a rising edge when `iValid & oReady`.
- `iBusy` input 1: risk core busy; a commit is deferred while high.
- `oMu` output 18: µ operand for `Main.iMu`.
- `oSigma` output 18: σ operand for `Main.iSigma`.
- `oS` output 18: S operand for `Main.iS`.
- `oLoad` output 1: one-cycle pulse; new operands are valid in the same cycle.
- `oErr` output 1: one-cycle pulse; frame rejected.
- `oErrCode` output 2: 01 checksum, 10 nonzero pad, 11 timeout; held until the next error.

## Operation
- Frame layout: `HDR`, 9 payload bytes, 1 checksum byte.
- Payload order: µ, then σ, then S. Each is 3 bytes, MSB first, occupying 24 bits with the value in bits [17:0]. Bits [23:18] are pad and must be 0.
- Checksum: XOR of the 9 payload bytes; the header is excluded.
- State IDLE: `oReady`=1.
  - Accepted byte == `HDR` → PAYLOAD, index=0, XOR accumulator=0, pad flag cleared.
  - Any other byte is discarded silently, with no error.
- State PAYLOAD: `oReady`=1.
  - Each accepted byte is shifted into the shadow register selected by index (0–2 µ, 3–5 σ, 6–8 S) and XORed into the accumulator.
  - On bytes 0, 3 and 6, any of bits [7:2] set raises the pad flag.
  - Index 8 accepted → CSUM.
- State CSUM: `oReady`=1. On an accepted byte:
  - byte ≠ accumulator → error code 01, back to IDLE.
  - else pad flag set → error code 10, back to IDLE.
  - else → COMMIT.
  - Checksum error has priority over pad error.
- State COMMIT: `oReady`=0.
  - On the first edge with `iBusy`=0: shadow registers copy to `oMu`/`oSigma`/`oS`, `oLoad`=1 for exactly one cycle, state → IDLE.
  - While `iBusy`=1, stay in COMMIT indefinitely; no timeout applies.
- Timeout:
  - The gap counter clears on every accepted byte and on entry to PAYLOAD.
  - It increments each cycle in PAYLOAD/CSUM without a transfer.
  - On reaching `TIMEOUT`-1: error code 11, → IDLE, partial frame dropped.
- On any error, `oMu`/`oSigma`/`oS` keep their previous values; shadow registers are don't-care.
- Reset (any time, including mid-frame or in COMMIT):
  - State IDLE; index, accumulator, pad flag and gap counter cleared.
  - `oMu`=`oSigma`=`oS`=0, `oLoad`=0, `oErr`=0, `oErrCode`=00, `oReady`=1 once reset is released.
  - A pending commit is lost.

## Timing
- All outputs are registered; `oReady` is decoded from the state register only, never from `iValid`.
- Commit latency: checksum byte accepted at edge N, `iBusy`=0 → state COMMIT after N. Outputs and `oLoad`=1 after edge N+1; `oLoad`=0 after N+2.
- With `iBusy` high: `oLoad` follows the edge after the first cycle in which `iBusy` is sampled low.
- Error latency: `oErr`/`oErrCode` update on the edge that accepts the checksum byte, or on the edge at which the timeout count is reached. `oErr` is high for one cycle.
- Back-to-back frames: a header can be accepted on the cycle `oLoad` is high (state is IDLE). Minimum frame period is 12 cycles with `iBusy` low.
- `oMu`/`oSigma`/`oS` change only on the `oLoad` edge or on reset.

## Test plan
- Reset, then send A5 00 00 B8 00 0D 50 00 60 00 85 with `iBusy`=0 → one `oLoad` pulse 1 cycle after the checksum; `oMu`=184, `oSigma`=3408, `oS`=24576; `oErr` never high.
- Same frame with `iBusy`=1 held 20 cycles after the checksum → `oReady`=0 throughout, outputs unchanged. `oLoad` occurs on the edge after `iBusy` falls.
- Same frame with checksum 0x84 → `oErr` pulse, `oErrCode`=01, outputs keep their prior values, no `oLoad`. Then garbage bytes 0x11, 0x22 followed by a valid frame → accepted normally.
- µ bytes 04 00 B8 with a correct checksum (0x81) → `oErrCode`=10, no `oLoad`.
- Header plus 4 payload bytes, then `iValid`=0 for `TIMEOUT` cycles → `oErrCode`=11 exactly `TIMEOUT`-1 cycles after the last transfer. A following valid frame loads correctly.
- Assert `RST_N` low mid-payload and again in COMMIT → all outputs 0 and state IDLE immediately. No `oLoad` after release until a complete new frame arrives.
